mac_unit: RTL and testbench

MAC_UNIT -- requirements
Module: mac_unit

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_digit_step.sv | 25 ++
 rtl/mac_unit.sv | 100 ++++++++++
 tb/tb_mac_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the iterative multiply-accumulate unit.
// Holds the FSM state encoding, default widths and derived iteration count.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } mac_state_t;

    localparam int MAC_WIDTH = 32;
    localparam int MAC_DIGIT = 4;
    localparam int ITER      = MAC_WIDTH / MAC_DIGIT;

    // Counter width for n iterations, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_digit_step.sv
// One radix-2^DIGIT multiply step: sum = partial + ((a << DIGIT*k) * digit k of b).
// Ports: partial/a/b operands (WIDTH), k digit index (KW), sum result (WIDTH).
module mac_digit_step #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] partial,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] sum
);

    logic [DIGIT-1:0] dig;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] product;

    assign dig     = b[k*DIGIT +: DIGIT];
    assign shifted = a << (k * DIGIT);
    // Everything is truncated to WIDTH: the result is defined modulo 2^WIDTH.
    assign product = shifted * WIDTH'(dig);
    assign sum     = partial + product;

endmodule

// File: rtl/mac_unit.sv
// Iterative multiply-accumulate unit retiring DIGIT multiplier bits per cycle.
// Ports: clk, rst_n (sync, active-low), mac_start, acc_clr, op_a, op_b,
//        mac_out (accumulator), mac_control_mem (new-result pulse), mac_busy.
module mac_unit
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int DIGIT = MAC_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mac_start,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] mac_out,
    output logic             mac_control_mem,
    output logic             mac_busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_bits(STEPS);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("mac_unit: WIDTH must be a multiple of DIGIT");
    end

    mac_state_t       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] step_sum;
    logic [CW-1:0]    cnt;
    logic             clr_q;

    mac_digit_step #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT),
        .KW    (CW)
    ) u_step (
        .partial (part),
        .a       (a_q),
        .b       (b_q),
        .k       (cnt),
        .sum     (step_sum)
    );

    assign mac_out = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            part            <= '0;
            acc             <= '0;
            cnt             <= '0;
            clr_q           <= 1'b0;
            mac_control_mem <= 1'b0;
            mac_busy        <= 1'b0;
        end else begin
            mac_control_mem <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mac_start) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        part     <= '0;
                        cnt      <= '0;
                        clr_q    <= acc_clr;
                        mac_busy <= 1'b1;
                        state    <= MUL;
                    end else if (acc_clr) begin
                        acc <= '0;
                    end
                end
                MUL: begin
                    part <= step_sum;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(STEPS - 1)) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    // A clear requested with the start replaces the old total.
                    acc             <= clr_q ? part : acc + part;
                    mac_control_mem <= 1'b1;
                    mac_busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mac_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: transaction-level model plus directed scenarios.
// Compares every cycle at the falling edge and pins the model with literal results.
module tb_mac_unit;
    import mac_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mac_start = 1'b0;
    logic         acc_clr = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] mac_out;
    logic         mac_control_mem;
    logic         mac_busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mac_unit #(.WIDTH(W), .DIGIT(MAC_DIGIT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mac_start       (mac_start),
        .acc_clr         (acc_clr),
        .op_a            (op_a),
        .op_b            (op_b),
        .mac_out         (mac_out),
        .mac_control_mem (mac_control_mem),
        .mac_busy        (mac_busy)
    );

    always #5 clk = ~clk;

    // Transaction model: an accepted start yields its result ITER+1 edges later.
    int           remaining = 0;
    logic [W-1:0] pend_val = '0;
    logic [W-1:0] exp_out = '0;
    logic         exp_pulse = 1'b0;
    logic         exp_busy = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            remaining <= 0;
            exp_out   <= '0;
            exp_pulse <= 1'b0;
            exp_busy  <= 1'b0;
        end else if (remaining == 0) begin
            exp_pulse <= 1'b0;
            if (mac_start) begin
                pend_val  <= (acc_clr ? '0 : exp_out) + op_a * op_b;
                remaining <= ITER + 1;
                exp_busy  <= 1'b1;
            end else if (acc_clr) begin
                exp_out <= '0;
            end
        end else begin
            remaining <= remaining - 1;
            exp_pulse <= 1'b0;
            if (remaining == 1) begin
                exp_out   <= pend_val;
                exp_pulse <= 1'b1;
                exp_busy  <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out", mac_out, exp_out);
            check("model_pulse", W'(mac_control_mem), W'(exp_pulse));
            check("model_busy", W'(mac_busy), W'(exp_busy));
        end
    end

    // Start one operation from the current (idle) cycle and wait for its pulse.
    task automatic run_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic clr,
                          input logic [W-1:0] want);
        int lat;
        lat = 0;
        op_a      = a;
        op_b      = b;
        acc_clr   = clr;
        mac_start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            mac_start = 1'b0;
            acc_clr   = 1'b0;
            if (mac_control_mem) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, W'(lat), W'(ITER + 2));
        check({name, "_out"}, mac_out, want);
    endtask

    int pulses;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_out", mac_out, 32'h0);
        check("reset_pulse", W'(mac_control_mem), 32'h0);
        check("reset_busy", W'(mac_busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scenarios 1-2: clear-start 3*5, then 2*7 started on the pulse cycle.
        run_op("s1", 32'd3, 32'd5, 1'b1, 32'd15);
        run_op("s2", 32'd2, 32'd7, 1'b0, 32'd29);
        @(negedge clk);

        // Scenario 3: modular wrap.
        run_op("s3a", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE);
        run_op("s3b", 32'h0001_0000, 32'h0001_0000, 1'b0, 32'hFFFF_FFFE);
        run_op("s3c", 32'd1, 32'd2, 1'b0, 32'h0000_0000);
        @(negedge clk);

        // Scenario 4: stray start and clear during an operation are ignored.
        pulses    = 0;
        op_a      = 32'd6;
        op_b      = 32'd7;
        acc_clr   = 1'b1;
        mac_start = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            mac_start = (i == 3);
            acc_clr   = (i == 5);
            if (i == 3) begin
                op_a = 32'd9;
                op_b = 32'd9;
            end
            if (mac_control_mem) pulses++;
        end
        check("s4_pulses", W'(pulses), 32'd1);
        check("s4_out", mac_out, 32'd42);

        // Scenario 5: reset at T+4 aborts with no pulse.
        pulses    = 0;
        op_a      = 32'd5;
        op_b      = 32'd5;
        mac_start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            mac_start = 1'b0;
            rst_n     = (i != 3);
            if (i == 4) begin
                check("s5_rst_out", mac_out, 32'd0);
                check("s5_rst_busy", W'(mac_busy), 32'd0);
            end
            if (mac_control_mem) pulses++;
        end
        check("s5_pulses", W'(pulses), 32'd0);
        run_op("s5b", 32'd4, 32'd4, 1'b1, 32'd16);
        run_op("s5c", 32'd3, 32'd3, 1'b0, 32'd25);
        @(negedge clk);

        // Scenario 6: idle clear.
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("s6_out", mac_out, 32'd0);
        check("s6_pulse", W'(mac_control_mem), 32'd0);
        repeat (3) @(negedge clk);
        check("s6_hold", mac_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
